// File: rtl/tug_playfield.sv
// Two-player tug-of-war playfield: one position register drives a one-hot LED bar,
// with edge scoring, a blank hold phase after each point, and a latched match winner.
module tug_playfield #(
  parameter int N_LIGHTS    = 9,
  parameter int WIN_POINTS  = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                L,
  input  logic                                R,
  output logic [N_LIGHTS-1:0]                 lights,
  output logic [$clog2(N_LIGHTS)-1:0]         pos,
  output logic                                point_l,
  output logic                                point_r,
  output logic [$clog2(WIN_POINTS+1)-1:0]     score_l,
  output logic [$clog2(WIN_POINTS+1)-1:0]     score_r,
  output logic [1:0]                          winner
);

  localparam int PW = $clog2(N_LIGHTS);
  localparam int SW = $clog2(WIN_POINTS + 1);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0]       CENTRE       = PW'((N_LIGHTS - 1) / 2);
  localparam logic [PW-1:0]       LEFT_EDGE    = PW'(N_LIGHTS - 1);
  localparam logic [SW-1:0]       WIN          = SW'(WIN_POINTS);
  localparam logic [CW-1:0]       HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [N_LIGHTS-1:0] ONE          = {{(N_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [N_LIGHTS-1:0] CENTRE_LIGHT = ONE << CENTRE;
  localparam logic [N_LIGHTS-1:0] LEFT_LIGHT   = ONE << LEFT_EDGE;

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_POINT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state_q,   state_d;
  logic [PW-1:0]       pos_q,     pos_d;
  logic [N_LIGHTS-1:0] lights_q,  lights_d;
  logic [SW-1:0]       score_l_q, score_l_d;
  logic [SW-1:0]       score_r_q, score_r_d;
  logic [CW-1:0]       hold_q,    hold_d;
  logic [1:0]          winner_q,  winner_d;
  logic                point_l_q, point_l_d;
  logic                point_r_q, point_r_d;

  logic          move_l, move_r;
  logic [SW-1:0] score_l_inc, score_r_inc;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    hold_d      = hold_q;
    winner_d    = winner_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    move_l      = L & ~R;
    move_r      = R & ~L;
    score_l_inc = score_l_q + SW'(1);
    score_r_inc = score_r_q + SW'(1);

    case (state_q)
      S_PLAY: begin
        if (move_l) begin
          if (pos_q == LEFT_EDGE) begin
            score_l_d = score_l_inc;
            point_l_d = 1'b1;
            hold_d    = '0;
            if (score_l_inc == WIN) begin
              state_d  = S_DONE;
              winner_d = 2'b10;
            end else begin
              state_d  = S_POINT;
            end
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else if (move_r) begin
          if (pos_q == '0) begin
            score_r_d = score_r_inc;
            point_r_d = 1'b1;
            hold_d    = '0;
            if (score_r_inc == WIN) begin
              state_d  = S_DONE;
              winner_d = 2'b01;
            end else begin
              state_d  = S_POINT;
            end
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end
      // The point cycle itself is the first of the HOLD_CYCLES blank cycles.
      S_POINT: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_PLAY;
          pos_d   = CENTRE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + CW'(1);
        end
      end
      default: begin
      end
    endcase

    case (state_d)
      S_PLAY:  lights_d = ONE << pos_d;
      S_POINT: lights_d = '0;
      default: lights_d = (winner_d == 2'b10) ? LEFT_LIGHT : ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_PLAY;
      pos_q     <= CENTRE;
      lights_q  <= CENTRE_LIGHT;
      score_l_q <= '0;
      score_r_q <= '0;
      hold_q    <= '0;
      winner_q  <= 2'b00;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      lights_q  <= lights_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      hold_q    <= hold_d;
      winner_q  <= winner_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
    end
  end

  assign lights  = lights_q;
  assign pos     = pos_q;
  assign point_l = point_l_q;
  assign point_r = point_r_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign winner  = winner_q;

endmodule

// File: tb/tb_tug_playfield.sv
// Directed bench for tug_playfield: default 9-LED build plus a 3-LED single-point build.
module tb_tug_playfield;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_reset = 1'b0, d_L = 1'b0, d_R = 1'b0;
  logic [8:0] d_lights;
  logic [3:0] d_pos;
  logic       d_point_l, d_point_r;
  logic [2:0] d_score_l, d_score_r;
  logic [1:0] d_winner;

  logic       c_reset = 1'b0, c_L = 1'b0, c_R = 1'b0;
  logic [2:0] c_lights;
  logic [1:0] c_pos;
  logic       c_point_l, c_point_r;
  logic [0:0] c_score_l, c_score_r;
  logic [1:0] c_winner;

  tug_playfield dut_def (
    .clk(clk), .reset(d_reset), .L(d_L), .R(d_R),
    .lights(d_lights), .pos(d_pos), .point_l(d_point_l), .point_r(d_point_r),
    .score_l(d_score_l), .score_r(d_score_r), .winner(d_winner)
  );

  tug_playfield #(.N_LIGHTS(3), .WIN_POINTS(1), .HOLD_CYCLES(1)) dut_min (
    .clk(clk), .reset(c_reset), .L(c_L), .R(c_R),
    .lights(c_lights), .pos(c_pos), .point_l(c_point_l), .point_r(c_point_r),
    .score_l(c_score_l), .score_r(c_score_r), .winner(c_winner)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge, outputs are checked at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    d_reset = 1'b1; c_reset = 1'b1;
    tick();
    d_reset = 1'b0; c_reset = 1'b0;
    chk("rst_lights", d_lights, 9'b000010000);
    chk("rst_pos", d_pos, 4);
    chk("rst_score_l", d_score_l, 0);
    chk("rst_score_r", d_score_r, 0);
    chk("rst_winner", d_winner, 2'b00);
    chk("rst_points", {d_point_l, d_point_r}, 2'b00);

    d_L = 1'b1; tick(); d_L = 1'b0;
    chk("L_pos", d_pos, 5);
    chk("L_lights", d_lights, 9'b000100000);
    d_R = 1'b1; tick(); d_R = 1'b0;
    chk("R_pos", d_pos, 4);
    d_L = 1'b1; d_R = 1'b1; tick(); d_L = 1'b0; d_R = 1'b0;
    chk("LR_pos", d_pos, 4);
    tick();
    chk("idle_pos", d_pos, 4);

    d_L = 1'b1;
    repeat (4) tick();
    chk("edge_pos", d_pos, 8);
    chk("edge_lights", d_lights, 9'b100000000);
    tick();
    d_L = 1'b0; d_R = 1'b1;
    chk("ptl_pulse", d_point_l, 1'b1);
    chk("ptl_score", d_score_l, 1);
    chk("ptl_lights0", d_lights, 9'b0);
    chk("ptl_pos_hold", d_pos, 8);
    tick();
    chk("ptl_pulse_end", d_point_l, 1'b0);
    chk("ptl_lights1", d_lights, 9'b0);
    tick();
    chk("ptl_lights2", d_lights, 9'b0);
    tick();
    chk("ptl_lights3", d_lights, 9'b0);
    chk("ptl_pos_ign", d_pos, 8);
    chk("ptl_score_r_ign", d_score_r, 0);
    tick();
    d_R = 1'b0;
    chk("recentre_lights", d_lights, 9'b000010000);
    chk("recentre_pos", d_pos, 4);
    chk("recentre_score_l", d_score_l, 1);
    d_L = 1'b1; tick(); d_L = 1'b0;
    chk("first_play_press", d_pos, 5);
    d_R = 1'b1; tick(); d_R = 1'b0;
    chk("back_centre", d_pos, 4);

    for (int p = 1; p <= 7; p++) begin
      d_R = 1'b1;
      repeat (5) tick();
      d_R = 1'b0;
      chk("ptr_pulse", d_point_r, 1'b1);
      chk("ptr_score", d_score_r, p);
      if (p < 7) begin
        chk("ptr_lights0", d_lights, 9'b0);
        repeat (4) tick();
        chk("ptr_recentre", d_pos, 4);
      end
    end
    chk("win_winner", d_winner, 2'b01);
    chk("win_lights", d_lights, 9'b000000001);
    chk("win_score_r", d_score_r, 7);
    tick();
    chk("win_pulse_end", d_point_r, 1'b0);
    d_L = 1'b1; tick(); d_L = 1'b0;
    d_R = 1'b1; tick(); d_R = 1'b0;
    chk("done_lights", d_lights, 9'b000000001);
    chk("done_pos", d_pos, 0);
    chk("done_score_r", d_score_r, 7);
    chk("done_score_l", d_score_l, 1);
    chk("done_winner", d_winner, 2'b01);
    chk("done_pulses", {d_point_l, d_point_r}, 2'b00);

    d_reset = 1'b1; d_L = 1'b1;
    tick();
    d_reset = 1'b0; d_L = 1'b0;
    chk("rstdone_pos", d_pos, 4);
    chk("rstdone_lights", d_lights, 9'b000010000);
    chk("rstdone_scores", {d_score_l, d_score_r}, 6'd0);
    chk("rstdone_winner", d_winner, 2'b00);

    d_L = 1'b1;
    repeat (5) tick();
    d_L = 1'b0;
    chk("mid_point_l", d_point_l, 1'b1);
    tick();
    d_reset = 1'b1;
    tick();
    d_reset = 1'b0;
    chk("rstmid_pos", d_pos, 4);
    chk("rstmid_lights", d_lights, 9'b000010000);
    chk("rstmid_score_l", d_score_l, 0);
    chk("rstmid_pulses", {d_point_l, d_point_r}, 2'b00);
    repeat (4) tick();
    chk("rstmid_stay", d_lights, 9'b000010000);
    d_R = 1'b1; tick(); d_R = 1'b0;
    chk("rstmid_play", d_pos, 3);

    chk("min_rst_lights", c_lights, 3'b010);
    chk("min_rst_pos", c_pos, 1);
    c_R = 1'b1; tick();
    chk("min_R_pos", c_pos, 0);
    chk("min_R_lights", c_lights, 3'b001);
    tick();
    c_R = 1'b0;
    chk("min_point_r", c_point_r, 1'b1);
    chk("min_winner", c_winner, 2'b01);
    chk("min_lights", c_lights, 3'b001);
    chk("min_score_r", c_score_r, 1);
    tick();
    chk("min_pulse_end", c_point_r, 1'b0);
    chk("min_lights_held", c_lights, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tug_playfield.md
# tug_playfield

Parametrised two-player tug-of-war playfield. It replaces the per-LED light cells with one position register driving an N-wide one-hot LED bar. It adds point scoring at the edges, a post-point hold/recentre phase, per-player score counters and a latched match winner. It sits between the debounced player-key pulse logic and the LED/score display drivers.

## Interface
Parameters:
- N_LIGHTS, default 9: number of playfield LEDs; must be odd and ≥3.
- WIN_POINTS, default 7: points needed to win the match; ≥1.
- HOLD_CYCLES, default 4: length of the post-point blank phase in cycles; ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- L  in  1  left-player press, one-cycle pulse; pulls the light left.
- R  in  1  right-player press, one-cycle pulse; pulls the light right.
- lights  out  N_LIGHTS  LED bar; bit N_LIGHTS-1 is the leftmost LED, bit 0 the rightmost.
- pos  out  $clog2(N_LIGHTS)  current light index.
- point_l  out  1  one-cycle pulse when the left player scores.
- point_r  out  1  one-cycle pulse when the right player scores.
- score_l  out  $clog2(WIN_POINTS+1)  left player's points.
- score_r  out  $clog2(WIN_POINTS+1)  right player's points.
- winner  out  2  match winner: 2'b00 none, 2'b10 left, 2'b01 right.

## Operation
- The FSM has three states: PLAY, POINT, DONE. All outputs are registered.
- Reset state: PLAY, pos = C = (N_LIGHTS-1)/2, lights = one-hot at C, scores 0, winner 00, point_l/point_r 0, hold counter 0.
- Move decode in PLAY: a move requires exactly one of L, R. If L and R are both 1, or both 0, pos holds.
- PLAY, L alone, pos < N_LIGHTS-1: pos increments.
- PLAY, R alone, pos > 0: pos decrements.
- PLAY, L alone, pos = N_LIGHTS-1: left scores.
  - score_l increments.
  - point_l pulses.
  - Next state is POINT, or DONE if the new score_l = WIN_POINTS.
- PLAY, R alone, pos = 0: right scores, mirror of the left case.
- POINT:
  - lights = all zero.
  - pos holds its edge value.
  - L and R are ignored.
  - The hold counter counts HOLD_CYCLES cycles, then the block returns to PLAY with pos = C.
- DONE:
  - lights = one-hot at the winner's edge (bit N_LIGHTS-1 for left, bit 0 for right).
  - winner is latched; scores are frozen.
  - L and R are ignored.
  - Only reset leaves DONE.
- Scores never exceed WIN_POINTS. Only one player can score per cycle, because scoring requires exactly one key.
- point_l and point_r are never both 1. Each is high for exactly one cycle per point, including the winning point.
- lights in PLAY is always one-hot and equals 1 << pos.

## Timing
- A press sampled at edge k updates pos and lights in the cycle after edge k. Latency is 1 cycle; back-to-back pulses move one LED per cycle.
- Scoring press sampled at edge k:
  - In the cycle after edge k: point_x = 1, score updated, lights = 0 (POINT) or the edge one-hot (DONE), winner set if DONE.
  - point_x returns to 0 the following cycle.
- POINT occupies exactly HOLD_CYCLES cycles, the first being the point_x cycle. The first PLAY cycle shows lights at C, and a press in that cycle is honoured.
- Reset asserted at any edge, including mid-POINT or in DONE, forces the full reset state in the following cycle. Any press in that same cycle is dropped.

## Test plan
- Reset, defaults (N=9): lights = 9'b000010000, pos = 4, scores 0, winner 00. Then L, R, and L+R pulses give pos = 5, 4, 4 respectively.
- Left point: from centre, 4 L pulses reach pos = 8; a 5th L gives point_l = 1 for one cycle, score_l = 1, lights = 0 for 4 cycles, then lights = 9'b000010000.
- Ignore during POINT: R pulses on every POINT cycle leave pos, scores and the return-to-centre timing unchanged.
- Match win: 7 right points give winner = 01, lights = 9'b000000001, score_r = 7 held. Further L/R pulses cause no change.
- Reset mid-POINT and in DONE: one reset cycle gives pos = 4, scores 0, winner 00, point pulses 0.
- Corner config N_LIGHTS=3, WIN_POINTS=1, HOLD_CYCLES=1:
  - From reset (lights = 3'b010), one R gives pos = 0.
  - A second R gives point_r = 1, winner = 01, lights = 3'b001, with no intermediate POINT state.
